// File: rtl/mmio_csr_mgr.sv
// MMIO CSR manager: serves DFH/AFU ID/status/counter/application CSRs to the host,
// merges downstream AFU read responses ahead of locally queued responses.

module mmio_csr_ctr #(
    parameter int CTR_WIDTH = 48,
    parameter int EVT_WIDTH = 3,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic [EVT_WIDTH-1:0] evt,
    output logic [CTR_WIDTH-1:0] cnt
);
    logic [EVT_WIDTH-1:0] evt_q;
    logic [CTR_WIDTH:0]   sum;

    // one spare bit catches the carry used for saturation
    assign sum = {1'b0, cnt} + {{(CTR_WIDTH + 1 - EVT_WIDTH){1'b0}}, evt_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_q <= '0;
            cnt   <= '0;
        end else begin
            evt_q <= evt;
            if (clr)
                cnt <= '0;
            else if (SATURATE && sum[CTR_WIDTH])
                cnt <= '1;
            else
                cnt <= sum[CTR_WIDTH-1:0];
        end
    end
endmodule

module mmio_csr_mgr #(
    parameter int           NUM_APP_CSRS         = 8,
    parameter int           NUM_CTRS             = 4,
    parameter int           CTR_WIDTH            = 48,
    parameter int           EVT_WIDTH            = 3,
    parameter bit           SATURATE             = 1'b0,
    parameter int           RSP_FIFO_DEPTH       = 4,
    parameter int           NEXT_DFH_BYTE_OFFSET = 0,
    parameter logic [127:0] AFU_ID               = 128'h0,
    parameter int           CLK_FREQ_MHZ         = 0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            mmio_req_valid,
    input  logic                            mmio_req_is_rd,
    input  logic [15:0]                     mmio_req_addr,
    input  logic [8:0]                      mmio_req_tid,
    input  logic [63:0]                     mmio_req_data,
    input  logic                            afu_rd_rsp_valid,
    input  logic [8:0]                      afu_rd_rsp_tid,
    input  logic [63:0]                     afu_rd_rsp_data,
    output logic                            host_rd_rsp_valid,
    output logic [8:0]                      host_rd_rsp_tid,
    output logic [63:0]                     host_rd_rsp_data,
    input  logic [64*NUM_APP_CSRS-1:0]      app_rd_data,
    output logic [NUM_APP_CSRS-1:0]         app_wr_en,
    output logic [63:0]                     app_wr_data,
    input  logic [EVT_WIDTH*NUM_CTRS-1:0]   ctr_event,
    output logic                            rsp_fifo_overflow
);
    localparam int         AW        = $clog2(RSP_FIFO_DEPTH);
    localparam logic [16:0] LOCAL_LIM = 17'(2 * (32 + NUM_APP_CSRS));

    typedef struct packed {
        logic [8:0]  tid;
        logic [63:0] data;
    } rsp_t;

    // vld_pipe[0]: local request at the port, vld_pipe[1]: registered request
    logic [1:0]  vld_pipe;
    logic        r1_rd;
    logic [14:0] r1_idx;
    logic [8:0]  r1_tid;
    logic [63:0] r1_data;

    assign vld_pipe[0] = mmio_req_valid && ({1'b0, mmio_req_addr} < LOCAL_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe[1] <= 1'b0;
            r1_rd       <= 1'b0;
            r1_idx      <= '0;
            r1_tid      <= '0;
            r1_data     <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            r1_rd       <= mmio_req_is_rd;
            r1_idx      <= mmio_req_addr[15:1];
            r1_tid      <= mmio_req_tid;
            r1_data     <= mmio_req_data;
        end
    end

    logic wr_q, rd_q, ctr_clr;
    assign wr_q    = vld_pipe[1] && !r1_rd;
    assign rd_q    = vld_pipe[1] && r1_rd;
    assign ctr_clr = wr_q && (r1_idx == 15'd9) && r1_data[0];

    logic [NUM_CTRS-1:0][CTR_WIDTH-1:0] ctr;

    for (genvar g = 0; g < NUM_CTRS; g++) begin : g_ctr
        mmio_csr_ctr #(
            .CTR_WIDTH(CTR_WIDTH),
            .EVT_WIDTH(EVT_WIDTH),
            .SATURATE (SATURATE)
        ) u_ctr (
            .clk    (clk),
            .reset_n(reset_n),
            .clr    (ctr_clr),
            .evt    (ctr_event[g*EVT_WIDTH +: EVT_WIDTH]),
            .cnt    (ctr[g])
        );
    end

    logic [63:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (r1_idx)
            15'd0: rd_data = {4'h1, 19'b0, (NEXT_DFH_BYTE_OFFSET == 0),
                              24'(NEXT_DFH_BYTE_OFFSET), 16'b0};
            15'd1: rd_data = AFU_ID[63:0];
            15'd2: rd_data = AFU_ID[127:64];
            15'd8: rd_data = 64'(CLK_FREQ_MHZ);
            15'd9: rd_data = {48'b0, 8'(NUM_CTRS), 6'b0, rsp_fifo_overflow, SATURATE};
            default: rd_data = '0;
        endcase
        for (int i = 0; i < NUM_CTRS; i++)
            if (r1_idx == 15'(16 + i)) rd_data = 64'(ctr[i]);
        for (int i = 0; i < NUM_APP_CSRS; i++)
            if (r1_idx == 15'(32 + i)) rd_data = app_rd_data[i*64 +: 64];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            app_wr_en   <= '0;
            app_wr_data <= '0;
        end else begin
            for (int i = 0; i < NUM_APP_CSRS; i++)
                app_wr_en[i] <= wr_q && (r1_idx == 15'(32 + i));
            if (wr_q) app_wr_data <= r1_data;
        end
    end

    rsp_t        fifo_mem [RSP_FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push, pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push       = rd_q && !fifo_full;
    // AFU responses always win the host port; local ones wait
    assign pop        = !fifo_empty && !afu_rd_rsp_valid;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= '{tid: r1_tid, data: rd_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            rsp_fifo_overflow <= 1'b0;
            host_rd_rsp_valid <= 1'b0;
            host_rd_rsp_tid   <= '0;
            host_rd_rsp_data  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (rd_q && fifo_full) rsp_fifo_overflow <= 1'b1;

            host_rd_rsp_valid <= afu_rd_rsp_valid || !fifo_empty;
            if (afu_rd_rsp_valid) begin
                host_rd_rsp_tid  <= afu_rd_rsp_tid;
                host_rd_rsp_data <= afu_rd_rsp_data;
            end else if (!fifo_empty) begin
                host_rd_rsp_tid  <= fifo_mem[rd_ptr[AW-1:0]].tid;
                host_rd_rsp_data <= fifo_mem[rd_ptr[AW-1:0]].data;
            end
        end
    end
endmodule

// File: tb/tb_mmio_csr_mgr.sv
// Scoreboard bench for mmio_csr_mgr: saturating instance A and wrapping instance B.

module tb_mmio_csr_mgr;
    localparam logic [127:0] AID = 128'hAAAA_AAAA_AAAA_AAAA_BBBB_BBBB_BBBB_BBBB;
    localparam int NAPP = 8;
    localparam int NCTR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        req_valid, req_is_rd, sel_b;
    logic [15:0] req_addr;
    logic [8:0]  req_tid;
    logic [63:0] req_data;
    logic        afu_valid;
    logic [8:0]  afu_tid;
    logic [63:0] afu_data;
    logic [64*NAPP-1:0] app_rd_data;
    logic [3*NCTR-1:0]  ctr_event;

    logic        a_valid, b_valid, a_ovf, b_ovf;
    logic [8:0]  a_tid, b_tid;
    logic [63:0] a_data, b_data, a_wr_data, b_wr_data;
    logic [NAPP-1:0] a_wr_en, b_wr_en;

    mmio_csr_mgr #(.NUM_APP_CSRS(NAPP), .NUM_CTRS(NCTR), .CTR_WIDTH(8), .EVT_WIDTH(3),
                   .SATURATE(1'b1), .RSP_FIFO_DEPTH(4), .NEXT_DFH_BYTE_OFFSET(0),
                   .AFU_ID(AID), .CLK_FREQ_MHZ(100)) u_a (
        .clk(clk), .reset_n(reset_n),
        .mmio_req_valid(req_valid && !sel_b), .mmio_req_is_rd(req_is_rd),
        .mmio_req_addr(req_addr), .mmio_req_tid(req_tid), .mmio_req_data(req_data),
        .afu_rd_rsp_valid(afu_valid), .afu_rd_rsp_tid(afu_tid), .afu_rd_rsp_data(afu_data),
        .host_rd_rsp_valid(a_valid), .host_rd_rsp_tid(a_tid), .host_rd_rsp_data(a_data),
        .app_rd_data(app_rd_data), .app_wr_en(a_wr_en), .app_wr_data(a_wr_data),
        .ctr_event(ctr_event), .rsp_fifo_overflow(a_ovf));

    mmio_csr_mgr #(.NUM_APP_CSRS(NAPP), .NUM_CTRS(NCTR), .CTR_WIDTH(8), .EVT_WIDTH(3),
                   .SATURATE(1'b0), .RSP_FIFO_DEPTH(4), .NEXT_DFH_BYTE_OFFSET(24'h1000),
                   .AFU_ID(AID), .CLK_FREQ_MHZ(100)) u_b (
        .clk(clk), .reset_n(reset_n),
        .mmio_req_valid(req_valid && sel_b), .mmio_req_is_rd(req_is_rd),
        .mmio_req_addr(req_addr), .mmio_req_tid(req_tid), .mmio_req_data(req_data),
        .afu_rd_rsp_valid(1'b0), .afu_rd_rsp_tid(9'd0), .afu_rd_rsp_data(64'd0),
        .host_rd_rsp_valid(b_valid), .host_rd_rsp_tid(b_tid), .host_rd_rsp_data(b_data),
        .app_rd_data(app_rd_data), .app_wr_en(b_wr_en), .app_wr_data(b_wr_data),
        .ctr_event(ctr_event), .rsp_fifo_overflow(b_ovf));

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
    } exp_t;

    exp_t q_loc[$], q_afu[$], q_b[$];
    int   n_vec = 0, n_err = 0;
    int   loc_seen = 0;
    logic prev_afu = 1'b0;
    exp_t e_mon, e_monb;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // tid[8] set marks a forwarded AFU response, clear marks a local one
    always @(negedge clk) begin
        if (a_valid) begin
            if (a_tid[8]) begin
                if (q_afu.size() == 0) chk("afu_unexpected", 64'(a_tid), 64'h1ff);
                else begin
                    e_mon = q_afu.pop_front();
                    chk("afu_tid", 64'(a_tid), 64'(e_mon.tid));
                    chk("afu_data", a_data, e_mon.data);
                end
            end else begin
                loc_seen++;
                chk("loc_prio", 64'(prev_afu), 64'd0);
                if (q_loc.size() == 0) chk("loc_unexpected", 64'(a_tid), 64'h1ff);
                else begin
                    e_mon = q_loc.pop_front();
                    chk("loc_tid", 64'(a_tid), 64'(e_mon.tid));
                    chk("loc_data", a_data, e_mon.data);
                end
            end
        end
        if (b_valid) begin
            if (q_b.size() == 0) chk("b_unexpected", 64'(b_tid), 64'h1ff);
            else begin
                e_monb = q_b.pop_front();
                chk("b_tid", 64'(b_tid), 64'(e_monb.tid));
                chk("b_data", b_data, e_monb.data);
            end
        end
        prev_afu = afu_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] addr, input logic [8:0] tid, input logic [63:0] exp,
                      input bit to_b, input bit expect_rsp);
        req_valid = 1'b1; req_is_rd = 1'b1; req_addr = addr; req_tid = tid; sel_b = to_b;
        if (expect_rsp) begin
            if (to_b) q_b.push_back('{tid: tid, data: exp});
            else      q_loc.push_back('{tid: tid, data: exp});
        end
        tick();
        req_valid = 1'b0; sel_b = 1'b0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [63:0] data);
        req_valid = 1'b1; req_is_rd = 1'b0; req_addr = addr; req_data = data; sel_b = 1'b0;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic afu_beats(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            afu_valid = 1'b1;
            afu_tid   = 9'(256 + base + i);
            afu_data  = 64'hF00D_0000_0000_0000 | 64'(base + i);
            q_afu.push_back('{tid: afu_tid, data: afu_data});
            tick();
        end
        afu_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (q_loc.size() == 0 && q_afu.size() == 0 && q_b.size() == 0) break;
            tick();
        end
        tick(); tick(); tick();
    endtask

    localparam logic [63:0] DFH_A = 64'h1000_0100_0000_0000;
    localparam logic [63:0] DFH_B = 64'h1000_0000_1000_0000;

    initial begin
        int base_seen;
        reset_n = 1'b0; req_valid = 1'b0; req_is_rd = 1'b0; sel_b = 1'b0;
        req_addr = '0; req_tid = '0; req_data = '0;
        afu_valid = 1'b0; afu_tid = '0; afu_data = '0; ctr_event = '0;
        for (int i = 0; i < NAPP; i++) app_rd_data[i*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(i);

        #12;
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_wr_en", 64'(a_wr_en), 64'd0);
        chk("rst_ovf", 64'(a_ovf), 64'd0);
        tick();
        reset_n = 1'b1;
        tick(); tick();

        // read latency: valid exactly three cycles after the request
        rd(16'h0002, 9'd5, AID[63:0], 1'b0, 1'b1);
        tick();
        chk("lat_early", 64'(a_valid), 64'd0);
        tick();
        chk("lat_valid", 64'(a_valid), 64'd1);
        chk("lat_tid", 64'(a_tid), 64'd5);
        tick();

        rd(16'h0000, 9'd10, DFH_A, 1'b0, 1'b1);
        rd(16'h0001, 9'd11, DFH_A, 1'b0, 1'b1);
        rd(16'h0004, 9'd12, AID[127:64], 1'b0, 1'b1);
        rd(16'h0006, 9'd13, 64'd0, 1'b0, 1'b1);
        rd(16'h000A, 9'd14, 64'd0, 1'b0, 1'b1);
        rd(16'h0010, 9'd15, 64'd100, 1'b0, 1'b1);
        rd(16'h0012, 9'd16, 64'h0000_0000_0000_0401, 1'b0, 1'b1);
        rd(16'h0044, 9'd17, 64'hC0DE_0000_0000_0002, 1'b0, 1'b1);
        rd(16'h004F, 9'd18, 64'hC0DE_0000_0000_0007, 1'b0, 1'b1);
        rd(16'h0050, 9'd19, 64'd0, 1'b0, 1'b0);
        rd(16'h0000, 9'd20, DFH_B, 1'b1, 1'b1);
        rd(16'h0012, 9'd21, 64'h0000_0000_0000_0400, 1'b1, 1'b1);
        drain();

        // application write strobe timing
        wr(16'(2 * (32 + 3)), 64'hDEAD);
        chk("wr_early", 64'(a_wr_en), 64'd0);
        tick();
        chk("wr_en", 64'(a_wr_en), 64'h08);
        chk("wr_data", a_wr_data, 64'hDEAD);
        tick();
        chk("wr_en_1cyc", 64'(a_wr_en), 64'd0);
        wr(16'(2 * (32 + 7)), 64'hBEEF);
        tick();
        chk("wr_en_last", 64'(a_wr_en), 64'h80);
        chk("wr_data_last", a_wr_data, 64'hBEEF);
        wr(16'h0050, 64'h1234);
        wr(16'h000A, 64'h5678);
        for (int i = 0; i < 3; i++) begin
            chk("wr_ignored", 64'(a_wr_en), 64'd0);
            tick();
        end

        // AFU responses hold off a local response
        base_seen = loc_seen;
        fork
            rd(16'h0002, 9'd30, AID[63:0], 1'b0, 1'b1);
            afu_beats(3, 0);
        join
        drain();
        chk("prio_loc_count", 64'(loc_seen - base_seen), 64'd1);

        // overflow: six reads into a four-entry FIFO while AFU traffic blocks drain
        base_seen = loc_seen;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    rd(16'h0004, 9'(40 + i), AID[127:64], 1'b0, i < 4);
            end
            afu_beats(10, 16);
        join
        drain();
        chk("ovf_delivered", 64'(loc_seen - base_seen), 64'd4);
        chk("ovf_flag", 64'(a_ovf), 64'd1);
        rd(16'h0012, 9'd50, 64'h0000_0000_0000_0403, 1'b0, 1'b1);
        drain();

        // counters: 40 cycles of +7 saturates at 8 bits on A, wraps to 24 on B
        ctr_event[2:0] = 3'd7;
        repeat (40) tick();
        ctr_event = '0;
        tick(); tick(); tick();
        rd(16'h0020, 9'd60, 64'h0000_0000_0000_00FF, 1'b0, 1'b1);
        rd(16'h0020, 9'd61, 64'd24, 1'b1, 1'b1);
        rd(16'h0022, 9'd62, 64'd0, 1'b0, 1'b1);
        wr(16'h0012, 64'h1);
        rd(16'h0020, 9'd63, 64'd0, 1'b0, 1'b1);
        rd(16'h0020, 9'd64, 64'd24, 1'b1, 1'b1);
        drain();

        // reset with reads in flight
        ctr_event[2:0] = 3'd3;
        repeat (5) tick();
        ctr_event = '0;
        rd(16'h0002, 9'd70, 64'd0, 1'b0, 1'b0);
        rd(16'h0002, 9'd71, 64'd0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(a_valid), 64'd0);
        tick(); tick();
        reset_n = 1'b1;
        repeat (6) begin
            chk("post_rst_quiet", 64'(a_valid), 64'd0);
            tick();
        end
        chk("post_rst_ovf", 64'(a_ovf), 64'd0);
        rd(16'h0012, 9'd80, 64'h0000_0000_0000_0401, 1'b0, 1'b1);
        rd(16'h0020, 9'd81, 64'd0, 1'b0, 1'b1);
        drain();

        chk("q_loc_empty", 64'(q_loc.size()), 64'd0);
        chk("q_afu_empty", 64'(q_afu.size()), 64'd0);
        chk("q_b_empty", 64'(q_b.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
